// File: rtl/keypad_pkg.sv
// Shared definitions for the oven keypad scan controller:
// FSM state encoding, default sizing and the named digit codes.
package keypad_pkg;

  localparam int DEFAULT_NUM_KEYS        = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    ACCEPT   = 3'd2,
    WAIT_REL = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  localparam logic [3:0] KEY_0 = 4'd0;
  localparam logic [3:0] KEY_1 = 4'd1;
  localparam logic [3:0] KEY_2 = 4'd2;
  localparam logic [3:0] KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8;
  localparam logic [3:0] KEY_9 = 4'd9;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key lines in, qualified key events out. The controller uses the slave
// view; the keypad/consumer side uses the master view.
interface keypad_scan_ctrl_if
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS = DEFAULT_NUM_KEYS,
  parameter int KEY_W    = $clog2(NUM_KEYS)
);
  logic [NUM_KEYS-1:0] keys;
  logic [KEY_W-1:0]    key_code;
  logic                key_valid;
  logic                key_held;
  logic                busy;

  modport master (
    output keys,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  busy
  );

  modport slave (
    input  keys,
    output key_code,
    output key_valid,
    output key_held,
    output busy
  );
endinterface

// File: rtl/keypad_scan_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: lowest asserted index wins.
// Kept generic so the start/stop/cancel keys can reuse it.
module prio_enc #(
  parameter int NUM_KEYS = 10,
  parameter int KEY_W    = $clog2(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic [KEY_W-1:0]    code,
  output logic                any_valid
);

  always_comb begin
    code = '0;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        code = KEY_W'(i);
      end
    end
  end

  assign any_valid = |keys;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Shared-counter debounce and arbitration for the keypad: one key event
// per qualified press, held flag until the release is qualified.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scan_ctrl_if.slave  bus
);

  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [KEY_W-1:0] captured_reg, captured_next;
  logic [KEY_W-1:0] code_reg, code_next;
  logic             held_reg, held_next;

  logic [KEY_W-1:0] candidate;
  logic             any_pressed;

  prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W)
  ) u_prio_enc (
    .keys      (bus.keys),
    .code      (candidate),
    .any_valid (any_pressed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      captured_reg <= '0;
      code_reg     <= '0;
      held_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      captured_reg <= captured_next;
      code_reg     <= code_next;
      held_reg     <= held_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    captured_next = captured_reg;
    code_next     = code_reg;
    held_next     = held_reg;

    case (state_reg)
      IDLE: begin
        if (any_pressed) begin
          captured_next = candidate;
          count_next    = CNT_ONE;
          state_next    = PRESS_DB;
        end
      end

      PRESS_DB: begin
        // A change of winner counts as a bounce, so a different key must
        // earn its own full debounce window from IDLE.
        if (!any_pressed || candidate != captured_reg) begin
          count_next = '0;
          state_next = IDLE;
        end else if (count_reg == CNT_LAST) begin
          // Code and held flag are loaded on entry so they align with the pulse.
          count_next = '0;
          code_next  = captured_reg;
          held_next  = 1'b1;
          state_next = ACCEPT;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end

      ACCEPT: begin
        state_next = WAIT_REL;
      end

      WAIT_REL: begin
        if (!any_pressed) begin
          count_next = CNT_ONE;
          state_next = REL_DB;
        end
      end

      REL_DB: begin
        if (any_pressed) begin
          count_next = '0;
          state_next = WAIT_REL;
        end else if (count_reg == CNT_LAST) begin
          count_next = '0;
          held_next  = 1'b0;
          state_next = IDLE;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end

      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.key_valid = (state_reg == ACCEPT);
  assign bus.key_code  = code_reg;
  assign bus.key_held  = held_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed self-checking bench for keypad_scan_ctrl with default sizing
// (10 keys, 8-cycle debounce).
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic       exp_valid;
  logic       exp_held;
  logic       exp_busy;
  logic [3:0] exp_code;

  keypad_scan_ctrl_if #(.NUM_KEYS(10)) bus ();

  keypad_scan_ctrl #(
    .NUM_KEYS        (10),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.keys = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.key_valid, bus.key_held, bus.key_code} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy/valid/held/code=%b/%b/%b/%0d, required all 0",
                 i, bus.busy, bus.key_valid, bus.key_held, bus.key_code);
      end
    end
    $display("test_reset done: 20 idle cycles checked");
  endtask

  task automatic test_single_key();
    bus.keys = 10'b0000100000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_valid = (i == 8);
      exp_held  = (i >= 8);
      exp_code  = (i >= 8) ? KEY_5 : KEY_0;
      n_checks++;
      if (bus.key_valid !== exp_valid || bus.key_held !== exp_held ||
          bus.busy !== 1'b1 || bus.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL key5_press cycle %0d: valid/held/busy/code=%b/%b/%b/%0d, required %b/%b/1/%0d",
                 i, bus.key_valid, bus.key_held, bus.busy, bus.key_code, exp_valid, exp_held, exp_code);
      end
    end
    bus.keys = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_held = (i < 8);
      exp_busy = (i < 8);
      n_checks++;
      if (bus.key_valid !== 1'b0 || bus.key_held !== exp_held ||
          bus.busy !== exp_busy || bus.key_code !== KEY_5) begin
        n_fail++;
        $display("FAIL key5_release cycle %0d: valid/held/busy/code=%b/%b/%b/%0d, required 0/%b/%b/5",
                 i, bus.key_valid, bus.key_held, bus.busy, bus.key_code, exp_held, exp_busy);
      end
    end
    $display("test_single_key done: key 5 press and release");
  endtask

  task automatic test_bounce();
    bus.keys = 10'b0000001000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_burst cycle %0d: valid/held=%b/%b, required 0/0",
                 i, bus.key_valid, bus.key_held);
      end
    end
    bus.keys = '0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_abort: busy/valid=%b/%b, required 0/0", bus.busy, bus.key_valid);
    end
    bus.keys = 10'b0000001000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_valid = (i == 8);
      exp_code  = (i >= 8) ? KEY_3 : KEY_5;
      n_checks++;
      if (bus.key_valid !== exp_valid || bus.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL bounce_press cycle %0d: valid/code=%b/%0d, required %b/%0d",
                 i, bus.key_valid, bus.key_code, exp_valid, exp_code);
      end
    end
    bus.keys = '0;
    for (int i = 1; i <= 10; i++) tick();
    n_checks++;
    if (bus.key_held !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_release: held/busy=%b/%b, required 0/0", bus.key_held, bus.busy);
    end
    $display("test_bounce done: key 3 after 5-cycle bounce");
  endtask

  task automatic test_simultaneous();
    bus.keys = 10'b0010000100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_valid = (i == 8);
      exp_code  = (i >= 8) ? KEY_2 : KEY_3;
      n_checks++;
      if (bus.key_valid !== exp_valid || bus.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL dual_press cycle %0d: valid/code=%b/%0d, required %b/%0d",
                 i, bus.key_valid, bus.key_code, exp_valid, exp_code);
      end
    end
    bus.keys = 10'b1010000100;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_checks++;
      if (bus.key_valid !== 1'b0 || bus.key_held !== 1'b1 || bus.key_code !== KEY_2) begin
        n_fail++;
        $display("FAIL extra_key9 cycle %0d: valid/held/code=%b/%b/%0d, required 0/1/2",
                 i, bus.key_valid, bus.key_held, bus.key_code);
      end
    end
    bus.keys = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_held = (i < 8);
      n_checks++;
      if (bus.key_held !== exp_held || bus.key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dual_release cycle %0d: held/valid=%b/%b, required %b/0",
                 i, bus.key_held, bus.key_valid, exp_held);
      end
    end
    $display("test_simultaneous done: keys 2+7 then 9 while held");
  endtask

  task automatic test_release_glitch();
    bus.keys = 10'b0000010000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_valid = (i == 8);
      n_checks++;
      if (bus.key_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL glitch_press cycle %0d: valid=%b, required %b", i, bus.key_valid, exp_valid);
      end
    end
    n_checks++;
    if (bus.key_code !== KEY_4) begin
      n_fail++;
      $display("FAIL glitch_code: code=%0d, required 4", bus.key_code);
    end
    bus.keys = '0;
    for (int i = 1; i <= 5; i++) tick();
    bus.keys = 10'b0000010000;
    tick();
    n_checks++;
    if (bus.key_held !== 1'b1 || bus.busy !== 1'b1 || bus.key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_hold: held/busy/valid=%b/%b/%b, required 1/1/0",
               bus.key_held, bus.busy, bus.key_valid);
    end
    bus.keys = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_held = (i < 8);
      n_checks++;
      if (bus.key_held !== exp_held || bus.key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_release cycle %0d: held/valid=%b/%b, required %b/0",
                 i, bus.key_held, bus.key_valid, exp_held);
      end
    end
    $display("test_release_glitch done: key 4 release glitch at count 5");
  endtask

  task automatic test_reset_mid_debounce();
    bus.keys = 10'b0001000000;
    for (int i = 1; i <= 6; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.busy, bus.key_valid, bus.key_held, bus.key_code} !== 7'd0) begin
      n_fail++;
      $display("FAIL rst_mid_db: busy/valid/held/code=%b/%b/%b/%0d, required all 0",
               bus.busy, bus.key_valid, bus.key_held, bus.key_code);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_valid = (i == 8);
      exp_held  = (i >= 8);
      exp_code  = (i >= 8) ? KEY_6 : KEY_0;
      n_checks++;
      if (bus.key_valid !== exp_valid || bus.key_held !== exp_held || bus.key_code !== exp_code) begin
        n_fail++;
        $display("FAIL rst_restart cycle %0d: valid/held/code=%b/%b/%0d, required %b/%b/%0d",
                 i, bus.key_valid, bus.key_held, bus.key_code, exp_valid, exp_held, exp_code);
      end
    end
    bus.keys = '0;
    for (int i = 1; i <= 10; i++) tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_final_idle: busy/held=%b/%b, required 0/0", bus.busy, bus.key_held);
    end
    $display("test_reset_mid_debounce done: key 6 restart after reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.keys = '0;
    test_reset();
    test_single_key();
    test_bounce();
    test_simultaneous();
    test_release_glitch();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Shared debounce and arbitration controller for the oven keypad, sitting between raw key lines and the digit-entry/timer logic.
- Owns a single debounce counter and shares it across all NUM_KEYS key inputs.
- Picks one key by fixed priority, qualifies press and release, and emits exactly one encoded key event per physical press.
- Downstream logic consumes only key_valid/key_code and never sees raw key lines.

Parameters:
- NUM_KEYS, 10: number of key inputs (digits 0-9); keys[i] maps to code i.
- DEBOUNCE_CYCLES, 8: consecutive stable cycles required to accept a press or a release; legal range 2..255.
- KEY_W, $clog2(NUM_KEYS): key code width (4 for default); derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- keys  input  NUM_KEYS  raw key levels, 1 = pressed; already synchronised upstream
- key_code  output  KEY_W  code of the accepted key; held stable until the next accepted press
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high from acceptance until release is qualified
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, counter=0, captured key=0.
  - key_code=0, key_valid=0, key_held=0, busy=0.
  - Reset mid-operation aborts any debounce with no pulse emitted.
- Priority: the candidate is the lowest-index asserted bit of keys. Any keys != 0 means "pressed".
- States and transitions:
  - IDLE: if keys!=0, capture candidate, counter<=1, go to PRESS_DB.
  - PRESS_DB:
    - If keys==0 or candidate != captured key, go to IDLE with counter<=0 (bounce abort, no event).
    - Else counter<=counter+1.
    - When counter reaches DEBOUNCE_CYCLES-1 while still stable, go to ACCEPT.
  - ACCEPT (one cycle): key_valid=1, key_code<=captured key, key_held<=1; go to WAIT_REL unconditionally.
  - WAIT_REL:
    - If keys==0, counter<=1 and go to REL_DB.
    - Extra or different keys pressed while held are ignored; no new event and no re-arbitration.
  - REL_DB:
    - If keys!=0, go to WAIT_REL with counter<=0.
    - Else count; when counter reaches DEBOUNCE_CYCLES-1, key_held<=0 and go to IDLE.
- Latency:
  - A press stable from cycle T produces key_valid at T+DEBOUNCE_CYCLES.
  - A release stable from cycle R drops key_held at R+DEBOUNCE_CYCLES, after which IDLE accepts a new press on the next cycle.
- Simultaneous presses: the lower index wins.
  - If the winner releases during PRESS_DB while a higher key stays down, the candidate changes, which aborts to IDLE. The remaining key then starts a fresh debounce from IDLE.
- Counter width: $clog2(DEBOUNCE_CYCLES+1); the counter never wraps and saturates by construction of the transitions.
- key_valid is never high on two consecutive cycles. Exactly one pulse per accepted press, none on release.
- key_code changes only in ACCEPT.

Decomposition:
- Shared package keypad_pkg holds:
  - the state encoding (IDLE, PRESS_DB, ACCEPT, WAIT_REL, REL_DB);
  - the default constants NUM_KEYS=10 and DEBOUNCE_CYCLES=8;
  - the named code constants KEY_0..KEY_9.
- One sub-module: prio_enc. It is combinational, NUM_KEYS in, KEY_W code plus any_valid out, lowest index wins. Reusable for the future start/stop/cancel keys.
- FSM and counter stay in the top module.

Test Plan:
- Reset, then keys=0 for 20 cycles -> all outputs 0, busy=0 throughout.
- keys=10'b0000100000 (key 5) held 20 cycles from T:
  - key_valid=1 only at T+8, key_code=5, key_held=1.
  - keys=0 from R -> key_held=0 at R+8, busy=0 after.
- Bounce: key 3 high 5 cycles, low 1, high 12 -> no pulse for the first burst. A single pulse with code 3 arrives 8 cycles after the final rising level.
- keys=10'b0010000100 (keys 2 and 7) together -> single pulse, code 2. Pressing key 9 additionally while in WAIT_REL -> no pulse.
- Release glitch: during REL_DB drive keys=key 4 for 1 cycle at count 5 -> back to WAIT_REL, key_held stays 1, no pulse. A clean 8-cycle release then drops key_held.
- rst=1 asserted in PRESS_DB at count 6 -> next cycle all outputs 0, state IDLE, no key_valid. A held key restarts the full 8-cycle debounce after rst deasserts.
